rr_encoder: RTL and testbench

Sequential N-to-log2(N) request encoder: the counterpart of the team's one-hot decoders. It latches one or more request lines into a sticky pending set. It then issues each pending request, one at a time, as a binary index on a valid/ready output channel, using round-robin priority. It sits in front of mux/decoder selection logic: the emitted index drives a decoder `sel` once accepted.

---
 rtl/rr_encoder.sv | 116 +++++++++++
 tb/tb_rr_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder.sv
// rr_encoder: sequential N-to-log2(N) request encoder with round-robin priority.
//
// Requests are latched into a sticky pending set. Each pending request is offered,
// one at a time, as a binary index on a valid/ready channel. The search starts one
// past the most recently transferred index. Every output comes straight from a
// register.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous, active-high reset
//   req_i        request lines (multi-hot allowed), sampled every edge
//   enable_i     when low, req_i is ignored; the output channel keeps running
//   out_idx_o    index of the offered request
//   out_valid_o  out_idx_o holds a valid request
//   out_ready_i  consumer accepts; transfer = out_valid_o && out_ready_i at an edge
//   pending_o    current sticky pending set
module rr_encoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         enable_i,
  output logic [W-1:0] out_idx_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] pending_o
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [W-1:0] last_q, last_d;

  logic         xfer;
  logic         found;
  logic [W-1:0] sel_idx;

  assign xfer = (state_q == StOffer) && out_ready_i;

  // Round-robin search over the registered pending set, starting at last_q + 1.
  // N is a power of two, so W-bit addition wraps at N-1 back to 0.
  always_comb begin
    logic [W-1:0] cand;
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = last_q + W'(k);
      if (!found && pending_q[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // A new request in the same edge as its own transfer wins, so the request re-arms.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (enable_i && req_i[i]) begin
        pending_d[i] = 1'b1;
      end else if (xfer && (out_idx_q == W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      out_idx_q <= '0;
      last_q    <= W'(N - 1);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_idx_q <= out_idx_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic; out_idx_q is frozen for the whole offer.
  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    last_d    = last_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d   = StOffer;
          out_idx_d = sel_idx;
        end
      end
      StOffer: begin
        if (out_ready_i) begin
          state_d = StIdle;
          last_d  = out_idx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs, all decoded from registers only
  always_comb begin
    out_valid_o = (state_q == StOffer);
    out_idx_o   = out_idx_q;
    pending_o   = pending_q;
  end

endmodule

// File: tb/tb_rr_encoder.sv
// Directed testbench for rr_encoder with N=4 and hand-computed expectations.
module tb_rr_encoder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         enable;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] pending;

  int total = 0;
  int bad   = 0;

  rr_encoder #(.N(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .enable_i    (enable),
    .out_idx_o   (out_idx),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .pending_o   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [W-1:0] idx,
                           input logic [N-1:0] pend);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) check_eq({tag, ".idx"}, 32'(out_idx), 32'(idx));
    check_eq({tag, ".pending"}, 32'(pending), 32'(pend));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    enable    = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state, idle with no requests
    check_eq("rst.idx", 32'(out_idx), 32'd0);
    check_out("rst", 1'b0, 2'd0, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_out("idle", 1'b0, 2'd0, 4'b0000);
      check_eq("idle.idx", 32'(out_idx), 32'd0);
    end

    // Single pulse on req[2]
    out_ready = 1'b1;
    req = 4'b0100;
    tick();
    check_out("single.e0", 1'b0, 2'd0, 4'b0100);
    req = 4'b0000;
    tick();
    check_out("single.e1", 1'b1, 2'd2, 4'b0100);
    tick();
    check_out("single.e2", 1'b0, 2'd0, 4'b0000);

    // Multi-hot 1011 from reset: order 0, 1, 3
    do_reset();
    out_ready = 1'b1;
    req = 4'b1011;
    tick();
    check_out("multi.load", 1'b0, 2'd0, 4'b1011);
    req = 4'b0000;
    tick();
    check_out("multi.o0", 1'b1, 2'd0, 4'b1011);
    tick();
    check_out("multi.x0", 1'b0, 2'd0, 4'b1010);
    tick();
    check_out("multi.o1", 1'b1, 2'd1, 4'b1010);
    tick();
    check_out("multi.x1", 1'b0, 2'd0, 4'b1000);
    tick();
    check_out("multi.o3", 1'b1, 2'd3, 4'b1000);
    tick();
    check_out("multi.x3", 1'b0, 2'd0, 4'b0000);
    tick();
    check_out("multi.idle", 1'b0, 2'd0, 4'b0000);

    // last=3, so 1001 serves 0 before 3
    req = 4'b1001;
    tick();
    check_out("wrap.load", 1'b0, 2'd0, 4'b1001);
    req = 4'b0000;
    tick();
    check_out("wrap.o0", 1'b1, 2'd0, 4'b1001);
    tick();
    check_out("wrap.x0", 1'b0, 2'd0, 4'b1000);
    tick();
    check_out("wrap.o3", 1'b1, 2'd3, 4'b1000);
    tick();
    check_out("wrap.x3", 1'b0, 2'd0, 4'b0000);

    // Backpressure: offer idx 1, stall 6 cycles while req toggles
    out_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    check_out("bp.offer", 1'b1, 2'd1, 4'b0010);
    for (int c = 0; c < 6; c++) begin
      req = (c % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      check_out("bp.hold", 1'b1, 2'd1, 4'b1111);
    end
    req = 4'b0000;
    out_ready = 1'b1;
    tick();
    check_out("bp.xfer", 1'b0, 2'd0, 4'b1101);
    out_ready = 1'b0;
    tick();
    check_out("bp.next", 1'b1, 2'd2, 4'b1101);

    // Held request re-arms: pending[1] never clears
    do_reset();
    out_ready = 1'b1;
    req = 4'b0010;
    tick();
    check_out("hold.load", 1'b0, 2'd0, 4'b0010);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check_out("hold.cyc", (c % 2 == 0), 2'd1, 4'b0010);
    end
    req = 4'b0000;
    tick();
    check_out("hold.drop", 1'b0, 2'd0, 4'b0000);

    // enable=0 ignores requests
    enable = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out("en0", 1'b0, 2'd0, 4'b0000);
    end
    enable = 1'b1;
    req = 4'b0000;

    // Reset during an offer of idx 3
    do_reset();
    out_ready = 1'b0;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    check_out("rstoff.offer", 1'b1, 2'd3, 4'b1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rstoff.after", 1'b0, 2'd0, 4'b0000);
    check_eq("rstoff.idx", 32'(out_idx), 32'd0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    check_out("rstoff.new", 1'b1, 2'd0, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
